// File: rtl/hex_pkg.sv
// ----------------------------------------------------------------------------
// hex_pkg
// Shared seven-segment definitions for the hex digit decoders.
//   SEG_OFF    : segment pattern with every segment dark (active-low bus)
//   GLYPH_0..F : standard hex glyphs, bit order {g,f,e,d,c,b,a}, 0 = lit
//   hex_glyph  : nibble -> glyph lookup used by hex and hex_scan
// ----------------------------------------------------------------------------
package hex_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex.sv
// ----------------------------------------------------------------------------
// hex
// Combinational single-nibble seven-segment decoder.
//   nibble : 4-bit value to show
//   seg    : glyph {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module hex (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    import hex_pkg::*;

    assign seg = hex_glyph(nibble);

endmodule

// File: rtl/hex_scan.sv
// ----------------------------------------------------------------------------
// hex_scan
// Time-multiplexed DIGITS-digit seven-segment driver with double buffering.
// The host writes a pending buffer with load; the displayed buffer is only
// refreshed at the end of a full scan so a frame never shows mixed data.
//   clk, rst_n : clock, synchronous active-low reset
//   data       : nibble i = data[4i+3:4i], digit 0 rightmost
//   dp, en     : per-digit decimal point request / digit enable
//   blank_lz   : leading-zero blanking enable (digit 0 never blanked)
//   load       : captures data/dp/en into the pending buffer
//   seg, dp_o  : shared segment bus and decimal point, active-low
//   an         : anode strobes, polarity set by AN_ACTIVE_LOW
//   frame      : one-cycle pulse at the end of each full scan
// ----------------------------------------------------------------------------
module hex_scan #(
    parameter int DIGITS        = 4,
    parameter int DIV           = 50000,
    parameter int GAP           = 2,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);
    import hex_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   pend_data, disp_data;
    logic [DIGITS-1:0]     pend_dp, disp_dp;
    logic [DIGITS-1:0]     pend_en, disp_en;

    logic [DIGITS-1:0]     upper_zero;
    logic [DIGITS-1:0]     digit_sel;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  cur_lz;
    logic [6:0]            cur_glyph;
    logic                  slot_end;
    logic                  frame_edge;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_edge = slot_end && (idx == IDX_LAST);

    // upper_zero[i] is set when nibbles i..DIGITS-1 of the displayed value
    // are all zero; the digit mux then picks the current digit's fields.
    // Selecting by compare keeps non-power-of-two DIGITS safe.
    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (disp_data[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (disp_data[4*i +: 4] == 4'h0);
        end
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_lz    = 1'b0;
        digit_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib      = disp_data[4*i +: 4];
                cur_dp       = disp_dp[i];
                cur_en       = disp_en[i];
                cur_lz       = blank_lz && (i != 0) && upper_zero[i];
                digit_sel[i] = 1'b1;
            end
        end
    end

    hex u_hex (
        .nibble (cur_nib),
        .seg    (cur_glyph)
    );

    // Prescaler, digit index, double buffer and the registered output stage.
    // Outputs reflect the counters of the previous cycle, so the anti-ghost
    // gap lines up with the first GAP clocks of each slot one clock late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
            seg       <= SEG_OFF;
            dp_o      <= 1'b1;
            an        <= AN_OFF;
            frame     <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            frame <= frame_edge;

            // Displayed takes the pending value as it stood before this edge,
            // so a load on the boundary edge lands one frame later.
            if (frame_edge) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                disp_en   <= pend_en;
            end

            if (load) begin
                pend_data <= data;
                pend_dp   <= dp;
                pend_en   <= en;
            end

            if ((cnt < GAP_END) || !cur_en || cur_lz) begin
                seg  <= SEG_OFF;
                dp_o <= 1'b1;
                an   <= AN_OFF;
            end else begin
                seg  <= cur_glyph;
                dp_o <= ~cur_dp;
                an   <= AN_OFF ^ digit_sel;
            end
        end
    end

endmodule

// File: doc/hex_scan.md
Name: hex_scan

Overview:
- Multiplexed N-digit seven-segment display driver; successor to the single-nibble hex decoder.
- Time-multiplexes DIGITS hex nibbles onto one shared segment bus with per-digit anode strobes, per-digit decimal points, a per-digit enable and optional leading-zero blanking.
- Double-buffered, so host updates never tear a frame.
- Sits between the board-level digit pins and any register or counter that wants to show a value.

Parameters:
- DIGITS, 4: number of digits; at least 1.
- DIV, 50000: clocks per digit slot; at least GAP+1.
- GAP, 2: clocks at the start of each slot with all anodes off (anti-ghosting).
- AN_ACTIVE_LOW, 1: 1 means an anode is driven 0 when selected.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- data  in  4*DIGITS  nibble i = data[4i+3:4i]; digit 0 is least significant and rightmost.
- dp  in  DIGITS  decimal point request per digit; 1 = lit.
- en  in  DIGITS  per-digit enable; 0 forces the digit blank.
- blank_lz  in  1  leading-zero blanking enable.
- load  in  1  one-cycle strobe; captures data/dp/en into the pending buffer.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- dp_o  out  1  decimal point, active-low.
- an  out  DIGITS  anode selects, polarity set by AN_ACTIVE_LOW.
- frame  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All state updates only on rising clk; rst_n sampled only at clk.
- Reset values: cnt=0, idx=0, pending=0, displayed=0, seg=7'h7F, dp_o=1, an=all inactive, frame=0.
- Reset mid-operation: next edge restores all reset values; scan restarts at digit 0 with a full slot.
- Prescaler: cnt runs 0..DIV-1. At cnt==DIV-1, cnt<=0 and idx advances; idx wraps DIGITS-1 -> 0.
- Frame boundary: the edge where cnt==DIV-1 and idx==DIGITS-1.
  - displayed <= pending on that edge.
  - frame registers 1 for exactly one cycle on that edge.
  - Frame period = DIGITS*DIV clocks.
- Load: pending <= {data,dp,en} on any edge with load=1.
  - Multiple loads within one frame: the last one wins.
  - Load on the frame-boundary edge: displayed takes the old pending; the new value appears one frame later.
- Digit blank condition, from displayed, for digit i:
  - en[i]==0, or
  - blank_lz==1, i!=0, and nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never zero-blanked.
  - A blanked digit drives seg=7F, dp_o=1 and its anode inactive.
- Output register: seg/dp_o/an are registered, computed from the current cnt, idx and displayed. Outputs therefore lag the counters by one clock.
  - If cnt<GAP: an = all inactive, seg=7F, dp_o=1.
  - Otherwise: an = one-hot(idx), inverted when AN_ACTIVE_LOW=1; seg = standard hex glyph of nibble idx; dp_o = ~dp[idx].
- Glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Widths:
  - cnt width = $clog2(DIV), minimum 1.
  - idx width = $clog2(DIGITS), minimum 1.
  - No out-of-range idx is reachable.

Decomposition:
- Shared package hex_pkg holds:
  - the 16 glyph constants;
  - SEG_OFF=7'h7F;
  - a glyph lookup function usable by both hex and hex_scan.
- One sub-module instance: the existing nibble decoder hex, fed by the muxed nibble, output registered in hex_scan.
- Leading-zero logic, prescaler and double buffer stay in hex_scan.

Test Plan (DIGITS=4, DIV=4, GAP=1, AN_ACTIVE_LOW=1):
- Reset: hold rst_n=0 for 3 clocks with load=1 and data=16'hFFFF -> seg=7F, dp_o=1, an=4'hF, frame=0 throughout; displayed stays 0.
- Basic scan: load data=16'h12AF, en=F, dp=4'b0100, then wait one frame.
  - Per slot: 1 clock of an=F, then 3 clocks each of:
    - an=1110, seg=0001110;
    - an=1101, seg=0001000;
    - an=1011, seg=0100100, dp_o=0;
    - an=0111, seg=1111001.
  - frame pulses every 16 clocks.
- Leading zeros: blank_lz=1.
  - data=16'h0070 -> digits 3 and 2 blank (an never 0111 or 1011); digit 1 seg=1111000; digit 0 seg=1000000.
  - data=0 -> only digit 0 is lit, showing 1000000.
- Enable and override: data=16'h8888, en=4'b1010 -> only an=1101 and an=0111 are ever asserted, both with seg=0000000.
- Tear-free load: load 16'h5555 during the digit 2 slot of a frame showing 16'h0000.
  - Digits 2 and 3 still show 1000000 in that frame.
  - All digits show 0010010 starting with the slot after the frame pulse.
- Reset mid-scan: assert rst_n=0 for one clock during the digit 2 slot -> next clock shows reset values; after release the first lit anode is 1110, after GAP.
